// File: rtl/dcache_ctrl_if.sv
// Bundles the CPU M-stage request signals and the line-wide memory bus.
// The slave view is the cache controller; the master view is the CPU/memory environment.
interface dcache_ctrl_if;
    logic         LoadM;
    logic         MemWriteM;
    logic         ByteM;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         dhit;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  LoadM, MemWriteM, ByteM, addr, wdata, mem_rdata, mem_ready,
        output rdata, dhit, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output LoadM, MemWriteM, ByteM, addr, wdata, mem_rdata, mem_ready,
        input  rdata, dhit, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with 16-byte lines.
// Hits are served combinationally in IDLE; misses stall the CPU through WRITEBACK/REFILL.
module dcache_ctrl #(
    parameter int NLINES = 4
) (
    input logic         clk,
    input logic         reset,
    dcache_ctrl_if.slave bus
);
    localparam int IW = $clog2(NLINES);
    localparam int TW = 32 - 4 - IW;

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_t;

    state_t              state_q;
    logic [NLINES-1:0]   valid_q;
    logic [NLINES-1:0]   dirty_q;
    logic [TW-1:0]       tag_q  [NLINES];
    logic [127:0]        data_q [NLINES];
    logic                mem_req_q;
    logic                mem_we_q;
    logic [31:0]         mem_addr_q;
    logic [127:0]        mem_wdata_q;

    logic [IW-1:0]       idx;
    logic [TW-1:0]       tag;
    logic [127:0]        line;
    logic [31:0]         word;
    logic [7:0]          sel_byte;
    logic                req;
    logic                hit;

    assign idx      = bus.addr[4 +: IW];
    assign tag      = bus.addr[31 -: TW];
    assign line     = data_q[idx];
    // Misaligned word accesses ignore addr[1:0] and use the word at addr[3:2].
    assign word     = line[{bus.addr[3:2], 5'b0} +: 32];
    assign sel_byte = word[{bus.addr[1:0], 3'b0} +: 8];
    assign req      = bus.LoadM | bus.MemWriteM;
    assign hit      = (state_q == IDLE) && valid_q[idx] && (tag_q[idx] == tag);

    assign bus.rdata     = bus.ByteM ? {{24{sel_byte[7]}}, sel_byte} : word;
    assign bus.dhit      = (state_q == IDLE) && (!req || hit);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    // NOTE: only valid/dirty and the handshake are reset; tag and data arrays
    // are left unreset so they map onto plain storage, and valid=0 masks them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            valid_q   <= '0;
            dirty_q   <= '0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && hit) begin
                        if (bus.MemWriteM) begin
                            if (bus.ByteM)
                                data_q[idx][{bus.addr[3:0], 3'b0} +: 8] <= bus.wdata[7:0];
                            else
                                data_q[idx][{bus.addr[3:2], 5'b0} +: 32] <= bus.wdata;
                            dirty_q[idx] <= 1'b1;
                        end
                    end else if (req) begin
                        mem_req_q <= 1'b1;
                        if (valid_q[idx] && dirty_q[idx]) begin
                            state_q     <= WRITEBACK;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_q[idx], idx, 4'b0};
                            mem_wdata_q <= line;
                        end else begin
                            state_q    <= REFILL;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {tag, idx, 4'b0};
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_ready) begin
                        dirty_q[idx] <= 1'b0;
                        state_q      <= REFILL;
                        mem_we_q     <= 1'b0;
                        mem_addr_q   <= {tag, idx, 4'b0};
                    end
                end
                REFILL: begin
                    if (bus.mem_ready) begin
                        data_q[idx]  <= bus.mem_rdata;
                        tag_q[idx]   <= tag;
                        valid_q[idx] <= 1'b1;
                        dirty_q[idx] <= 1'b0;
                        state_q      <= IDLE;
                        mem_req_q    <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
